// File: rtl/mul_div_if.sv
// Request/result bundle for mul_div_unit.
//   start_i : request, accepted only when the unit is idle or just finished
//   op_i    : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src1_i  : multiplicand / dividend
//   src2_i  : multiplier / divisor
//   busy_o  : operation in progress
//   done_o  : one-cycle pulse, hi_o/lo_o valid
//   hi_o    : product upper half / remainder
//   lo_o    : product lower half / quotient
interface mul_div_if #(
  parameter int unsigned size = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [size-1:0] src1_i;
  logic [size-1:0] src2_i;
  logic            busy_o;
  logic            done_o;
  logic [size-1:0] hi_o;
  logic [size-1:0] lo_o;

  modport slave (
    input  start_i, op_i, src1_i, src2_i,
    output busy_o, done_o, hi_o, lo_o
  );

  modport master (
    output start_i, op_i, src1_i, src2_i,
    input  busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per cycle on
// operand magnitudes, followed by a sign-fix cycle. Latency is size+2 edges from accept to done.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : mul_div_if slave (start/op/operands in, busy/done/hi/lo out)
module mul_div_unit #(
  parameter int unsigned size = 32
) (
  input logic      clk_i,
  input logic      rst_i,
  mul_div_if.slave bus
);

  localparam int unsigned CntW = $clog2(size);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            neg_res_q, neg_res_d;   // product / quotient must be negated
  logic            neg_rem_q, neg_rem_d;   // remainder must be negated (dividend negative)
  logic            div_zero_q, div_zero_d;
  logic [size-1:0] acc_hi_q, acc_hi_d;     // running product high / partial remainder
  logic [size-1:0] acc_lo_q, acc_lo_d;     // multiplier bits / dividend bits -> quotient
  logic [size-1:0] b_q, b_d;               // multiplicand or divisor magnitude
  logic [size-1:0] src1_q, src1_d;         // raw dividend, returned on divide by zero
  logic [size-1:0] hi_q, hi_d;
  logic [size-1:0] lo_q, lo_d;

  logic            accept;
  logic            a_neg, b_neg;
  logic [size-1:0] a_mag, b_mag;
  logic [size:0]   mul_sum;
  logic [size:0]   rem_shift;
  logic            div_ge;
  logic [size-1:0] div_sub;
  logic [2*size-1:0] prod, prod_neg;
  logic [size-1:0] fix_hi, fix_lo;

  assign accept = bus.start_i && ((state_q == StIdle) || (state_q == StDone));

  // op_i[0] selects signed operation for both multiply and divide
  assign a_neg = bus.op_i[0] & bus.src1_i[size-1];
  assign b_neg = bus.op_i[0] & bus.src2_i[size-1];
  assign a_mag = a_neg ? (~bus.src1_i + 1'b1) : bus.src1_i;
  assign b_mag = b_neg ? (~bus.src2_i + 1'b1) : bus.src2_i;

  // Multiply step: add multiplicand when current multiplier bit is set, then shift right.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(size+1){1'b0}});

  // Divide step: shift next dividend bit into the remainder and try subtracting the divisor.
  // When the trial succeeds the difference fits in size bits, so the narrow subtract suffices.
  assign rem_shift = {acc_hi_q, acc_lo_q[size-1]};
  assign div_ge    = rem_shift >= {1'b0, b_q};
  assign div_sub   = rem_shift[size-1:0] - b_q;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_neg = ~prod + 1'b1;

  // Sign correction applied in FIX. The signed overflow case (most-negative / -1) falls out
  // naturally: magnitude quotient is 2^(size-1), signs agree, remainder is zero.
  always_comb begin
    fix_hi = acc_hi_q;
    fix_lo = acc_lo_q;
    if (!is_div_q) begin
      if (neg_res_q) begin
        fix_hi = prod_neg[2*size-1:size];
        fix_lo = prod_neg[size-1:0];
      end
    end else if (div_zero_q) begin
      fix_hi = src1_q;
      fix_lo = {size{1'b1}};
    end else begin
      if (neg_res_q) fix_lo = ~acc_lo_q + 1'b1;
      if (neg_rem_q) fix_hi = ~acc_hi_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    b_d        = b_q;
    src1_d     = src1_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    if (accept) begin
      state_d    = StBusy;
      cnt_d      = '0;
      is_div_d   = bus.op_i[1];
      neg_res_d  = a_neg ^ b_neg;
      neg_rem_d  = a_neg;
      div_zero_d = (bus.src2_i == '0);
      acc_hi_d   = '0;
      src1_d     = bus.src1_i;
      if (bus.op_i[1]) begin
        acc_lo_d = a_mag;
        b_d      = b_mag;
      end else begin
        acc_lo_d = b_mag;
        b_d      = a_mag;
      end
    end else begin
      case (state_q)
        StBusy: begin
          if (is_div_q) begin
            acc_hi_d = div_ge ? div_sub : rem_shift[size-1:0];
            acc_lo_d = {acc_lo_q[size-2:0], div_ge};
          end else begin
            acc_hi_d = mul_sum[size:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[size-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(size - 1)) state_d = StFix;
        end
        StFix: begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          state_d = StDone;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      b_q        <= '0;
      src1_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      b_q        <= b_d;
      src1_q     <= src1_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy_o = (state_q == StBusy) || (state_q == StFix);
  assign bus.done_o = (state_q == StDone);
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mul_div_if #(.size(32)) bus ();

  mul_div_unit #(.size(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation from an idle/done state and wait for done_o.
  // inject: pulse start_i and scramble operands while busy (must be ignored).
  // stay:   return while still in DONE so the caller can chain a back-to-back start.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit inject, input bit stay,
                        output int lat);
    int n;
    int busy_low;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    n = 0;
    busy_low = 0;
    while (n < 40 && !bus.done_o) begin
      if (!bus.busy_o) busy_low++;
      if (inject && n == 4) begin
        bus.start_i = 1'b1;
        bus.op_i    = ~op;
        bus.src1_i  = ~a;
        bus.src2_i  = a ^ b ^ 32'h5A5A_5A5A;
      end
      if (inject && n == 5) bus.start_i = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    check({tag, ".latency"}, 64'(n), 64'd33);
    check({tag, ".busy_during"}, 64'(busy_low), 64'd0);
    check({tag, ".busy_at_done"}, 64'(bus.busy_o), 64'd0);
    check({tag, ".hi"}, 64'(bus.hi_o), 64'(exp_hi));
    check({tag, ".lo"}, 64'(bus.lo_o), 64'(exp_lo));
    if (!stay) begin
      bus.src1_i = $urandom;
      bus.src2_i = $urandom;
      @(posedge clk); #1;
      check({tag, ".done_pulse"}, 64'(bus.done_o), 64'd0);
      check({tag, ".hold"}, {bus.hi_o, bus.lo_o}, {exp_hi, exp_lo});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    rst_n       = 1'b0;
    bus.start_i = 1'b1;   // must be ignored while reset is low
    bus.op_i    = 2'b00;
    bus.src1_i  = 32'd3;
    bus.src2_i  = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 64'(bus.busy_o), 64'd0);
    check("rst.done", 64'(bus.done_o), 64'd0);
    check("rst.hi", 64'(bus.hi_o), 64'd0);
    check("rst.lo", 64'(bus.lo_o), 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
           1'b0, 1'b0, lat);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
           1'b1, 1'b0, lat);
    run_op("mult_negneg", 2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E,
           1'b0, 1'b0, lat);
    run_op("mult_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000,
           1'b0, 1'b0, lat);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           1'b0, 1'b0, lat);
    run_op("div_negdiv", 2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD,
           1'b0, 1'b0, lat);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0, lat);
    run_op("divu_zero", 2'b10, 32'h0000_0064, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF,
           1'b0, 1'b0, lat);
    run_op("div_zero", 2'b11, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
           1'b0, 1'b0, lat);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000,
           1'b0, 1'b0, lat);

    // Back-to-back: start issued in the DONE cycle of the previous op
    run_op("b2b_first", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000,
           1'b0, 1'b1, lat);
    run_op("b2b_second", 2'b10, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0, 1'b1, lat);
    check("b2b_gap", 64'(1 + lat), 64'd34);
    @(posedge clk); #1;

    // Reset at E10 of a running operation
    bus.start_i = 1'b1;
    bus.op_i    = 2'b00;
    bus.src1_i  = 32'h0000_1234;
    bus.src2_i  = 32'h0000_0010;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(posedge clk); #1;
    rst_n       = 1'b0;
    bus.start_i = 1'b1;
    #1;
    check("midrst.busy", 64'(bus.busy_o), 64'd0);
    check("midrst.done", 64'(bus.done_o), 64'd0);
    check("midrst.hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    begin
      int seen_done = 0;
      int seen_busy = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (bus.done_o) seen_done++;
        if (bus.busy_o) seen_busy++;
      end
      check("midrst.no_done", 64'(seen_done), 64'd0);
      check("midrst.no_busy", 64'(seen_busy), 64'd0);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: size, default 32, operand and result width.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-low.
REQ-004 start_i  input  1  request; sampled on a rising edge when accepting (REQ-012).
REQ-005 op_i  input  2  operation: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 src1_i  input  size  multiplicand / dividend.
REQ-007 src2_i  input  size  multiplier / divisor.
REQ-008 busy_o  output  1  high while an operation is in progress.
REQ-009 done_o  output  1  one-cycle pulse; results valid.
REQ-010 hi_o  output  size  product upper half / remainder; feeds result-select mux data input.
REQ-011 lo_o  output  size  product lower half / quotient; feeds result-select mux data input.

Function
REQ-012 States IDLE, BUSY, FIX, DONE; start_i accepted only in IDLE or DONE.
REQ-013 Accept edge E0: latch op_i, src1_i, src2_i; go to BUSY; iteration counter cleared.
REQ-014 Operand changes after E0 have no effect on the running operation.
REQ-015 BUSY: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, size steps, edges E1..E32 (size=32); last step moves to FIX.
REQ-016 Signed ops: iterate on magnitudes; FIX applies two's-complement correction (product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign). Unsigned ops pass through FIX unchanged.
REQ-017 FIX -> DONE at E33; done_o = 1 for exactly the DONE cycle; DONE -> IDLE at E34 unless start_i accepted (then -> BUSY, REQ-013).
REQ-018 busy_o = 1 in BUSY and FIX; 0 in IDLE and DONE.
REQ-019 start_i while busy_o = 1 ignored; no queuing.
REQ-020 hi_o/lo_o update only at the FIX->DONE edge; they hold through IDLE until the next DONE.
REQ-021 Multiply result: full 2*size-bit product, {hi_o, lo_o}.
REQ-022 Divide by zero (DIVU or DIV): lo_o = all ones, hi_o = src1 as latched; no sign correction; normal latency.
REQ-023 DIV overflow (src1 = most-negative, src2 = all ones): lo_o = most-negative value, hi_o = 0.
REQ-024 Latency fixed at size+2 edges from accept to done_o, independent of operand values.

Reset
REQ-025 rst_i low asynchronously forces IDLE; busy_o = 0, done_o = 0, hi_o = 0, lo_o = 0, counter and internal registers = 0.
REQ-026 Reset mid-operation aborts it; no done_o issued; first operation after release accepted normally.
REQ-027 start_i ignored while rst_i is low.

Verification
REQ-028 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done_o at E33 only, hi_o=0xFFFFFFFE, lo_o=0x00000001; busy_o high E0..E33.
REQ-029 MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB (-21).
REQ-030 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1); DIVU 100/7 -> lo_o=14, hi_o=2.
REQ-031 DIVU 0x00000064 / 0 -> lo_o=0xFFFFFFFF, hi_o=0x00000064; DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-032 start_i pulsed at E5 of a running op and src1_i/src2_i toggled -> ignored, original result unchanged; back-to-back start in DONE -> next done_o exactly 34 edges later.
REQ-033 rst_i low at E10 of an operation -> outputs 0 immediately, no done_o; after release, MULTU 6x7 -> lo_o=42, hi_o=0.
